mc_ctrl: RTL

Multi-cycle control unit for the RV32 subset CPU. It consumes the one-hot instruction-class flags and ALU_OP produced by the secondary decoder and sequences fetch, decode, execute, memory and write-back over several clocks. It drives every datapath strobe and mux select: PC, IR, register file, ALU operand muxes and data memory. It also counts retired instructions.

---
 rtl/mc_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences IF/ID/EX/MEM/WB for the RV32 subset CPU,
// drives all datapath strobes and mux selects, and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IS_R,
  input  logic             IS_IMM,
  input  logic             IS_LUI,
  input  logic             IS_LW,
  input  logic             IS_SW,
  input  logic             IS_BEQ,
  input  logic             IS_JAL,
  input  logic             IS_JALR,
  input  logic [3:0]       ALU_OP,
  input  logic             ZF,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             Write_Reg,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic [1:0]       PC_s,
  output logic             ALU_A_s,
  output logic [1:0]       ALU_B_s,
  output logic [1:0]       rd_s,
  output logic [3:0]       ALU_OP_out,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_IF      = 4'd1;
  localparam logic [3:0] S_ID      = 4'd2;
  localparam logic [3:0] S_EX_R    = 4'd3;
  localparam logic [3:0] S_EX_I    = 4'd4;
  localparam logic [3:0] S_WB_ALU  = 4'd5;
  localparam logic [3:0] S_WB_LUI  = 4'd6;
  localparam logic [3:0] S_EX_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD  = 4'd8;
  localparam logic [3:0] S_WB_LW   = 4'd9;
  localparam logic [3:0] S_MEM_WR  = 4'd10;
  localparam logic [3:0] S_EX_BEQ  = 4'd11;
  localparam logic [3:0] S_EX_JAL  = 4'd12;
  localparam logic [3:0] S_EX_JALR = 4'd13;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] PCS_PLUS4 = 2'b00;
  localparam logic [1:0] PCS_BRJ   = 2'b01;
  localparam logic [1:0] PCS_ALU   = 2'b10;

  localparam logic [1:0] BS_REG  = 2'b00;
  localparam logic [1:0] BS_IMM  = 2'b01;

  localparam logic [1:0] RD_ALU  = 2'b00;
  localparam logic [1:0] RD_IMM  = 2'b01;
  localparam logic [1:0] RD_LINK = 2'b10;
  localparam logic [1:0] RD_MDR  = 2'b11;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retired;

  logic w_pc_write;
  logic w_ir_write;
  logic w_write_reg;
  logic w_mem_read;
  logic w_mem_write;
  logic w_done;
  logic w_illegal;
  logic w_no_flag;

  assign w_no_flag = ~(IS_R | IS_IMM | IS_LUI | IS_LW | IS_SW | IS_BEQ | IS_JAL | IS_JALR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IDLE:    w_next = S_IF;
      S_IF:      w_next = S_ID;
      S_ID: begin
        if (IS_R)                w_next = S_EX_R;
        else if (IS_IMM)         w_next = S_EX_I;
        else if (IS_LUI)         w_next = S_WB_LUI;
        else if (IS_LW || IS_SW) w_next = S_EX_ADDR;
        else if (IS_BEQ)         w_next = S_EX_BEQ;
        else if (IS_JAL)         w_next = S_EX_JAL;
        else if (IS_JALR)        w_next = S_EX_JALR;
        else                     w_next = S_IF;
      end
      S_EX_R:    w_next = S_WB_ALU;
      S_EX_I:    w_next = S_WB_ALU;
      S_EX_ADDR: w_next = IS_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = mem_ready ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:  w_next = mem_ready ? S_IF : S_MEM_WR;
      default:   w_next = S_IF;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_write_reg = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    PC_s        = PCS_PLUS4;
    ALU_A_s     = 1'b0;
    ALU_B_s     = BS_REG;
    rd_s        = RD_ALU;
    ALU_OP_out  = ALU_ADD;
    case (r_state)
      S_IF: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        PC_s       = PCS_PLUS4;
      end
      S_ID:      w_illegal = w_no_flag;
      S_EX_R: begin
        ALU_B_s    = BS_REG;
        ALU_OP_out = ALU_OP;
      end
      S_EX_I: begin
        ALU_B_s    = BS_IMM;
        ALU_OP_out = ALU_OP;
      end
      S_WB_ALU: begin
        rd_s        = RD_ALU;
        w_write_reg = 1'b1;
        w_done      = 1'b1;
      end
      S_WB_LUI: begin
        rd_s        = RD_IMM;
        w_write_reg = 1'b1;
        w_done      = 1'b1;
      end
      S_EX_ADDR: begin
        ALU_B_s    = BS_IMM;
        ALU_OP_out = ALU_ADD;
      end
      S_MEM_RD:  w_mem_read = 1'b1;
      S_WB_LW: begin
        rd_s        = RD_MDR;
        w_write_reg = 1'b1;
        w_done      = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_done      = mem_ready;
      end
      // Branch compares A-B via subtract; the PC strobe follows ZF in the same cycle.
      S_EX_BEQ: begin
        ALU_B_s    = BS_REG;
        ALU_OP_out = ALU_SUB;
        PC_s       = PCS_BRJ;
        w_pc_write = ZF;
        w_done     = 1'b1;
      end
      S_EX_JAL: begin
        rd_s        = RD_LINK;
        w_write_reg = 1'b1;
        PC_s        = PCS_BRJ;
        w_pc_write  = 1'b1;
        w_done      = 1'b1;
      end
      S_EX_JALR: begin
        ALU_B_s     = BS_IMM;
        ALU_OP_out  = ALU_ADD;
        rd_s        = RD_LINK;
        w_write_reg = 1'b1;
        PC_s        = PCS_ALU;
        w_pc_write  = 1'b1;
        w_done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe immediately so an aborted instruction writes nothing.
  assign PC_Write   = w_pc_write  & ~rst;
  assign IR_Write   = w_ir_write  & ~rst;
  assign Write_Reg  = w_write_reg & ~rst;
  assign Mem_Read   = w_mem_read  & ~rst;
  assign Mem_Write  = w_mem_write & ~rst;
  assign instr_done = w_done      & ~rst;
  assign illegal    = w_illegal   & ~rst;
  assign state      = r_state;
  assign retired    = r_retired;

endmodule
